ica_sequencer: RTL and testbench
================================

// Module: ica_sequencer
// PURPOSE
// Top-level run sequencer for the FastICA processor. Starts whitening, streams the whitened
// block into RAM1 while FastICA starts, then runs FastICA over N_COMP components.
// Parametrised successor of the fixed single-pass main controller. Adds a start/done
// handshake, a multi-component loop with new_one pulses, a busy watchdog and error reporting.
// PARAMETERS
// ADDR_W    14   width of address_sel_mem1
// XFER_LEN  126  RAM1 write cycles per run, range 1..2**ADDR_W
// N_COMP    1    components extracted per run, range 1..16
// TMO_W     16   watchdog width; timeout = 2**TMO_W-1 cycles in a wait state
// PORTS
// clk               in   1       system clock; all flops on rising edge
// go                in   1       asynchronous active-low reset; low clears all state and outputs
// start             in   1       run request; sampled only in IDLE and ERR
// whitening_busy    in   1       whitening engine busy
// fastica_busy      in   1       FastICA engine busy
// go_whitening      out  1       whitening enable
// go_ram1           out  1       RAM1 enable
// rw                out  1       RAM1 direction; 1 = write
// address_sel_mem1  out  ADDR_W  RAM1 address
// go_fastica        out  1       FastICA enable
// new_one           out  1       one-cycle pulse: start the next component
// comp_idx          out  4       current component index
// busy              out  1       high from leaving IDLE until the FIN/ERR edge
// done              out  1       one-cycle pulse at normal run end
// err               out  1       sticky watchdog error
// BEHAVIOUR
// - Reset (go=0): state IDLE; every output 0; address/comp/watchdog counters 0.
// - Outputs are registered and decoded from next_state, so they change on the same edge as state.
// - State table. gw/gr/rw/gf = go_whitening/go_ram1/rw/go_fastica:
//   IDLE      0000  start=1 -> WH_GO
//   WH_GO     1000  -> WH_HOLD (busy ignored; covers engine busy-rise latency)
//   WH_HOLD   1000  -> WH_WAIT
//   WH_WAIT   1000  whitening_busy=0 -> XF_SETUP; else stay; watchdog expiry -> ERR
//   XF_SETUP  1100  address 0 -> XF
//   XF        1111  address = 0..XFER_LEN-1, +1 per cycle; at XFER_LEN-1 -> XF_END
//   XF_END    0101  address holds last value -> ICA_WAIT
//   ICA_WAIT  0001  address 0; fastica_busy=0 -> FIN if comp_idx==N_COMP-1, else NXT;
//                   watchdog expiry -> ERR
//   NXT       0000  new_one=1; comp_idx+1 -> ICA_GO
//   ICA_GO    0001  -> ICA_HOLD 0001 -> ICA_WAIT
//   FIN       0000  done=1 for one cycle; busy=0 -> IDLE
//   ERR       0000  err=1, busy=0; start=1 -> WH_GO with err cleared
// - rw is high exactly XFER_LEN cycles per run, with consecutive addresses and no repeats.
//   XFER_LEN=1 gives a single write cycle at address 0.
// - Watchdog clears on every state entry and counts only in WH_WAIT and ICA_WAIT.
//   If busy falls in the same cycle the watchdog expires, busy falling wins (no ERR).
// - comp_idx resets to 0 on every new run.
// - start is ignored outside IDLE/ERR. With start held high, runs go back-to-back with
//   exactly one IDLE cycle between FIN and WH_GO.
// - go low mid-run aborts immediately: outputs go to 0 asynchronously. No partial-run recovery.
// STRUCTURE
// - Package ica_pkg: state encoding localparams, RW_WRITE/RW_READ, comp_idx width constant.
// - One sub-module, ica_watchdog: TMO_W counter with clr/en inputs and an expired output.
//   The FSM, address counter and component counter stay inline.
// TESTING (XFER_LEN=8, N_COMP=2, TMO_W=5 unless stated)
// 1 Nominal: start pulse, whitening_busy high 10 cycles, fastica_busy low 5 cycles after XF_END
//   -> rw high 8 cycles with address 0..7; new_one once; comp_idx 0->1; one done pulse;
//   busy falls on the done edge.
// 2 Reset: go low during XF at address 3 -> all outputs 0 in the same cycle;
//   after release, start -> address restarts at 0.
// 3 Watchdog: whitening_busy stuck high -> err=1 after 31 WH_WAIT cycles, all enables 0;
//   start -> err=0, WH_GO.
// 4 Race: fastica_busy falls on the cycle the watchdog expires -> no err; proceeds to NXT.
// 5 Back-to-back: start held high -> two runs with one IDLE cycle between;
//   start pulses mid-run are ignored.
// 6 Boundary: XFER_LEN=1, N_COMP=1 -> single rw cycle at address 0; new_one never pulses;
//   done follows the first ICA_WAIT exit.

Source files
------------

// File: rtl/ica_pkg.sv
// Shared state encoding, RAM direction constants and enable decoding for the
// FastICA run sequencer.
package ica_pkg;

  localparam int   COMP_W   = 4;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WH_GO    = 4'd1;
  localparam logic [3:0] S_WH_HOLD  = 4'd2;
  localparam logic [3:0] S_WH_WAIT  = 4'd3;
  localparam logic [3:0] S_XF_SETUP = 4'd4;
  localparam logic [3:0] S_XF       = 4'd5;
  localparam logic [3:0] S_XF_END   = 4'd6;
  localparam logic [3:0] S_ICA_WAIT = 4'd7;
  localparam logic [3:0] S_NXT      = 4'd8;
  localparam logic [3:0] S_ICA_GO   = 4'd9;
  localparam logic [3:0] S_ICA_HOLD = 4'd10;
  localparam logic [3:0] S_FIN      = 4'd11;
  localparam logic [3:0] S_ERR      = 4'd12;

  typedef enum logic [3:0] {
    IDLE     = S_IDLE,
    WH_GO    = S_WH_GO,
    WH_HOLD  = S_WH_HOLD,
    WH_WAIT  = S_WH_WAIT,
    XF_SETUP = S_XF_SETUP,
    XF       = S_XF,
    XF_END   = S_XF_END,
    ICA_WAIT = S_ICA_WAIT,
    NXT      = S_NXT,
    ICA_GO   = S_ICA_GO,
    ICA_HOLD = S_ICA_HOLD,
    FIN      = S_FIN,
    ERR      = S_ERR
  } state_e;

  typedef struct packed {
    logic go_whitening;
    logic go_ram1;
    logic rw;
    logic go_fastica;
  } ctrl_t;

  // Engine enables implied by being in a given state.
  function automatic ctrl_t decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      WH_GO, WH_HOLD, WH_WAIT: c.go_whitening = 1'b1;
      XF_SETUP: begin
        c.go_whitening = 1'b1;
        c.go_ram1      = 1'b1;
      end
      XF: begin
        c.go_whitening = 1'b1;
        c.go_ram1      = 1'b1;
        c.rw           = RW_WRITE;
        c.go_fastica   = 1'b1;
      end
      XF_END: begin
        c.go_ram1    = 1'b1;
        c.rw         = RW_READ;
        c.go_fastica = 1'b1;
      end
      ICA_WAIT, ICA_GO, ICA_HOLD: c.go_fastica = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ica_watchdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags the
// cycle that completes 2**TMO_W-1 consecutive waiting cycles.
module ica_watchdog #(
  parameter int TMO_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Holding this value means the current cycle is the last one allowed.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] cnt;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + TMO_W'(1);
  end

  assign expired = en && (cnt == TMO_LAST);

endmodule

// File: rtl/ica_sequencer.sv
// Run sequencer for the FastICA processor: whitening, RAM1 block transfer, then
// one FastICA pass per component, with start/done handshake and watchdog error.
module ica_sequencer
  import ica_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int XFER_LEN = 126,
  parameter int N_COMP   = 1,
  parameter int TMO_W    = 16
) (
  input  logic              clk,
  input  logic              go,
  input  logic              start,
  input  logic              whitening_busy,
  input  logic              fastica_busy,
  output logic              go_whitening,
  output logic              go_ram1,
  output logic              rw,
  output logic [ADDR_W-1:0] address_sel_mem1,
  output logic              go_fastica,
  output logic              new_one,
  output logic [COMP_W-1:0] comp_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(XFER_LEN - 1);
  localparam logic [COMP_W-1:0] COMP_LAST = COMP_W'(N_COMP - 1);

  state_e            state, next_state;
  ctrl_t             ctrl_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [COMP_W-1:0] comp_nxt;
  logic              wd_clr, wd_en, wd_expired;

  ica_watchdog #(.TMO_W(TMO_W)) u_watchdog (
    .clk     (clk),
    .rst_n   (go),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign wd_clr = (next_state != state);
  assign wd_en  = (state == WH_WAIT) || (state == ICA_WAIT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = WH_GO;
      WH_GO:    next_state = WH_HOLD;
      WH_HOLD:  next_state = WH_WAIT;
      WH_WAIT:  if (!whitening_busy) next_state = XF_SETUP;
                else if (wd_expired) next_state = ERR;
      XF_SETUP: next_state = XF;
      XF:       if (address_sel_mem1 == ADDR_LAST) next_state = XF_END;
      XF_END:   next_state = ICA_WAIT;
      ICA_WAIT: if (!fastica_busy) next_state = (comp_idx == COMP_LAST) ? FIN : NXT;
                else if (wd_expired) next_state = ERR;
      NXT:      next_state = ICA_GO;
      ICA_GO:   next_state = ICA_HOLD;
      ICA_HOLD: next_state = ICA_WAIT;
      FIN:      next_state = IDLE;
      ERR:      if (start) next_state = WH_GO;
      default:  next_state = IDLE;
    endcase
  end

  // Address and component counters are computed against next_state so they
  // move on the same edge as the enables.
  always_comb begin
    addr_nxt = '0;
    if (next_state == XF && state == XF) addr_nxt = address_sel_mem1 + ADDR_W'(1);
    else if (next_state == XF_END)       addr_nxt = address_sel_mem1;

    comp_nxt = comp_idx;
    if (next_state == WH_GO)    comp_nxt = '0;
    else if (next_state == NXT) comp_nxt = comp_idx + COMP_W'(1);
  end

  always_ff @(posedge clk or negedge go) begin
    if (!go) begin
      state            <= IDLE;
      ctrl_q           <= '0;
      address_sel_mem1 <= '0;
      comp_idx         <= '0;
      new_one          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state            <= next_state;
      ctrl_q           <= decode(next_state);
      address_sel_mem1 <= addr_nxt;
      comp_idx         <= comp_nxt;
      new_one          <= (next_state == NXT);
      busy             <= !(next_state inside {IDLE, FIN, ERR});
      done             <= (next_state == FIN);
      err              <= (next_state == ERR);
    end
  end

  assign go_whitening = ctrl_q.go_whitening;
  assign go_ram1      = ctrl_q.go_ram1;
  assign rw           = ctrl_q.rw;
  assign go_fastica   = ctrl_q.go_fastica;

endmodule

// File: tb/tb_ica_sequencer.sv
// Directed bench for ica_sequencer: a cycle table for the nominal two-component
// run, then reset, watchdog, race, back-to-back and single-word boundary cases.
module tb_ica_sequencer;

  logic clk = 1'b0;
  logic go  = 1'b0;
  always #5 clk = ~clk;

  logic start, wb, fb;
  logic gw, gr, rw, gf, nw, bsy, dn, er;
  logic [13:0] addr;
  logic [3:0]  ci;

  logic b_start;
  logic b_gw, b_gr, b_rw, b_gf, b_nw, b_bsy, b_dn, b_er;
  logic [3:0] b_addr;
  logic [3:0] b_ci;

  ica_sequencer #(.ADDR_W(14), .XFER_LEN(8), .N_COMP(2), .TMO_W(5)) dut (
    .clk(clk), .go(go), .start(start), .whitening_busy(wb), .fastica_busy(fb),
    .go_whitening(gw), .go_ram1(gr), .rw(rw), .address_sel_mem1(addr),
    .go_fastica(gf), .new_one(nw), .comp_idx(ci), .busy(bsy), .done(dn), .err(er)
  );

  ica_sequencer #(.ADDR_W(4), .XFER_LEN(1), .N_COMP(1), .TMO_W(5)) dut_b (
    .clk(clk), .go(go), .start(b_start), .whitening_busy(1'b0), .fastica_busy(1'b0),
    .go_whitening(b_gw), .go_ram1(b_gr), .rw(b_rw), .address_sel_mem1(b_addr),
    .go_fastica(b_gf), .new_one(b_nw), .comp_idx(b_ci), .busy(b_bsy), .done(b_dn), .err(b_er)
  );

  typedef struct packed {
    logic [3:0]  en;    // go_whitening, go_ram1, rw, go_fastica
    logic [13:0] addr;
    logic        nw;
    logic [3:0]  ci;
    logic        bsy;
    logic        dn;
    logic        er;
  } outs_t;

  typedef struct {
    logic  start, wb, fb;
    outs_t exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic outs_t o(logic [3:0] en, int a, logic n, int c, logic b, logic d, logic e);
    outs_t r;
    r.en = en; r.addr = 14'(a); r.nw = n; r.ci = 4'(c); r.bsy = b; r.dn = d; r.er = e;
    return r;
  endfunction

  function automatic void add(logic s, logic w, logic f, outs_t e);
    vec_t v;
    v.start = s; v.wb = w; v.fb = f; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic outs_t grab();
    return o({gw, gr, rw, gf}, int'(addr), nw, int'(ci), bsy, dn, er);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    go = 1'b0; start = 1'b0; wb = 1'b0; fb = 1'b0; b_start = 1'b0;
    #3;
    go = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  found, rwc, nwc, done_at, addr_ok;
    outs_t got;

    // Nominal run: whitening busy 10 cycles, 8-word transfer, two components.
    add(1, 0, 0, o(4'b1000, 0, 0, 0, 1, 0, 0));                    // WH_GO
    for (int i = 0; i < 10; i++) add(0, 1, 0, o(4'b1000, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, o(4'b1100, 0, 0, 0, 1, 0, 0));                    // XF_SETUP
    for (int a = 0; a < 8; a++)                                    // XF, stray start at a=3
      add(logic'(a == 3), 0, 0, o(4'b1111, a, 0, 0, 1, 0, 0));
    add(0, 0, 1, o(4'b0101, 7, 0, 0, 1, 0, 0));                    // XF_END
    for (int i = 0; i < 5; i++) add(0, 0, 1, o(4'b0001, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, o(4'b0000, 0, 1, 1, 1, 0, 0));                    // NXT
    for (int i = 0; i < 5; i++) add(0, 0, 1, o(4'b0001, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, o(4'b0000, 0, 0, 1, 0, 1, 0));                    // FIN
    add(0, 0, 0, o(4'b0000, 0, 0, 1, 0, 0, 0));                    // IDLE

    start = 1'b0; wb = 1'b0; fb = 1'b0; b_start = 1'b0;
    #12;
    check("reset_outputs", 32'(grab()), 32'(outs_t'(0)));
    check("reset_outputs_b", {b_gw, b_gr, b_rw, b_gf, b_addr, b_nw, b_ci, b_bsy, b_dn, b_er}, 0);
    go = 1'b1;
    step();

    foreach (tbl[i]) begin
      start = tbl[i].start; wb = tbl[i].wb; fb = tbl[i].fb;
      step();
      got = grab();
      check($sformatf("nominal_row%0d", i), 32'(got), 32'(tbl[i].exp));
    end

    // Asynchronous reset in the middle of the transfer.
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (rw && addr == 14'd3) found = 1; else step();
    end
    check("t2_reach_addr3", found, 1);
    go = 1'b0;
    #1;
    check("t2_async_clear", 32'(grab()), 32'(outs_t'(0)));
    #2 go = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (rw) found = 1; else step();
    end
    check("t2_restart_seen", found, 1);
    check("t2_restart_addr", 32'(addr), 0);

    // Watchdog: whitening never finishes.
    do_reset();
    wb = 1'b1; start = 1'b1; step(); start = 1'b0;
    repeat (32) step();
    check("t3_before_expiry", {er, gw, bsy}, 3'b011);
    step();
    check("t3_err_set", {er, gw, gr, gf, bsy}, 5'b10000);
    start = 1'b1; step(); start = 1'b0;
    check("t3_restart", {er, gw, bsy, ci}, 7'b0110000);

    // FastICA busy drops in the same cycle the watchdog would expire.
    do_reset();
    fb = 1'b1; start = 1'b1; step(); start = 1'b0;
    repeat (43) step();
    check("t4_still_waiting", {er, gf, nw}, 3'b010);
    fb = 1'b0;
    step();
    check("t4_busy_wins", {er, nw, ci}, 6'b010001);

    // Back-to-back runs with start held high.
    do_reset();
    start = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (dn) found = 1;
    end
    check("t5_first_done", found, 1);
    step();
    check("t5_idle_gap", {bsy, gw, dn}, 3'b000);
    step();
    check("t5_second_start", {bsy, gw, ci}, 6'b110000);
    found = 0; rwc = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (rw) rwc++;
      if (dn) found = 1;
    end
    check("t5_second_done", found, 1);
    check("t5_second_rw_count", rwc, 8);
    start = 1'b0;
    step();
    check("t5_stays_idle", {bsy, gw}, 2'b00);

    // Single-word transfer, single component.
    do_reset();
    b_start = 1'b1; step(); b_start = 1'b0;
    check("t6_wh_go", {b_gw, b_bsy}, 2'b11);
    rwc = 0; nwc = 0; done_at = -1; addr_ok = 1;
    for (int e = 2; e <= 15; e++) begin
      step();
      if (b_rw) begin
        rwc++;
        if (b_addr != 4'd0) addr_ok = 0;
      end
      if (b_nw) nwc++;
      if (b_dn && done_at < 0) done_at = e;
    end
    check("t6_rw_count", rwc, 1);
    check("t6_rw_addr0", addr_ok, 1);
    check("t6_no_new_one", nwc, 0);
    check("t6_done_edge", done_at, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
